datapath: RTL and testbench



---
 rtl/datapath.sv | 192 +++++++++++++++++++
 tb/tb_datapath.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath with R0-R15, HI, LO, Y, Z, PC, IR,
// MAR, MDR, Inport, C and a combinational ALU. All transfers go over one bus.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [4:0]       opcode,
  input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, Yin, PCin, IRin, MARin, MDRin, Inportin, Cin,
  input  logic             Zin,
  input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout, LOout, Yout, PCout, IRout, MARout, MDRout, Inportout, Cout,
  input  logic             Zhighout, Zlowout,
  input  logic [WIDTH-1:0] Mdatain
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   r_d [16];
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, y_q, y_d, pc_q, pc_d;
  logic [WIDTH-1:0]   ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]   inport_q, inport_d, c_q, c_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [15:0]        r_in;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   quo, rem;
  logic [4:0]         shamt;

  // Register-named views for hierarchical observation; internal logic reads these.
  logic [WIDTH-1:0]   R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
  logic [WIDTH-1:0]   HI, LO, Y, PC, IR, MAR, MDR, Inport, C;
  logic [2*WIDTH-1:0] Z;

  assign R0  = r_q[0];   assign R1  = r_q[1];   assign R2  = r_q[2];   assign R3  = r_q[3];
  assign R4  = r_q[4];   assign R5  = r_q[5];   assign R6  = r_q[6];   assign R7  = r_q[7];
  assign R8  = r_q[8];   assign R9  = r_q[9];   assign R10 = r_q[10];  assign R11 = r_q[11];
  assign R12 = r_q[12];  assign R13 = r_q[13];  assign R14 = r_q[14];  assign R15 = r_q[15];
  assign HI = hi_q;  assign LO = lo_q;  assign Y = y_q;  assign PC = pc_q;
  assign IR = ir_q;  assign MAR = mar_q;  assign MDR = mdr_q;  assign Inport = inport_q;
  assign C  = c_q;   assign Z = z_q;

  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Bus source select: earlier entries win when several drive strobes overlap.
  always_comb begin
    bus = '0;
    if      (R0out)     bus = R0;
    else if (R1out)     bus = R1;
    else if (R2out)     bus = R2;
    else if (R3out)     bus = R3;
    else if (R4out)     bus = R4;
    else if (R5out)     bus = R5;
    else if (R6out)     bus = R6;
    else if (R7out)     bus = R7;
    else if (R8out)     bus = R8;
    else if (R9out)     bus = R9;
    else if (R10out)    bus = R10;
    else if (R11out)    bus = R11;
    else if (R12out)    bus = R12;
    else if (R13out)    bus = R13;
    else if (R14out)    bus = R14;
    else if (R15out)    bus = R15;
    else if (HIout)     bus = HI;
    else if (LOout)     bus = LO;
    else if (Zhighout)  bus = Z[2*WIDTH-1:WIDTH];
    else if (Zlowout)   bus = Z[WIDTH-1:0];
    else if (PCout)     bus = PC;
    else if (MDRout)    bus = MDR;
    else if (Inportout) bus = Inport;
    else if (Cout)      bus = C;
    else if (IRout)     bus = IR;
    else if (MARout)    bus = MAR;
    else if (Yout)      bus = Y;
  end

  // ALU: A is Y, B is the bus; IncPC overrides the opcode with bus+1.
  always_comb begin
    alu_res = '0;
    rot     = '0;
    quo     = '0;
    rem     = '0;
    shamt   = bus[4:0];
    if (IncPC) begin
      alu_res[WIDTH-1:0] = bus + WIDTH'(1);
    end else begin
      case (opcode)
        OP_ADD:  alu_res[WIDTH-1:0] = Y + bus;
        OP_SUB:  alu_res[WIDTH-1:0] = Y - bus;
        OP_SHR:  alu_res[WIDTH-1:0] = Y >> shamt;
        OP_SHRA: alu_res[WIDTH-1:0] = $signed(Y) >>> shamt;
        OP_SHL:  alu_res[WIDTH-1:0] = Y << shamt;
        OP_ROR: begin
          rot = {Y, Y} >> shamt;
          alu_res[WIDTH-1:0] = rot[WIDTH-1:0];
        end
        OP_ROL: begin
          rot = {Y, Y} << shamt;
          alu_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
        end
        OP_AND:  alu_res[WIDTH-1:0] = Y & bus;
        OP_OR:   alu_res[WIDTH-1:0] = Y | bus;
        OP_MUL:  alu_res = $signed({{WIDTH{Y[WIDTH-1]}}, Y}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
        OP_DIV: begin
          // Zero divisor and the one overflowing quotient are pinned explicitly
          // so the result never depends on simulator or library behaviour.
          if (bus == '0) begin
            quo = '0;
            rem = Y;
          end else if (Y == MOST_NEG && bus == '1) begin
            quo = MOST_NEG;
            rem = '0;
          end else begin
            quo = $signed(Y) / $signed(bus);
            rem = $signed(Y) % $signed(bus);
          end
          alu_res = {rem, quo};
        end
        OP_NEG:  alu_res[WIDTH-1:0] = -bus;
        OP_NOT:  alu_res[WIDTH-1:0] = ~bus;
        default: alu_res = '0;
      endcase
    end
  end

  // Next-state for every register: load on its strobe, otherwise hold.
  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    hi_d     = HIin     ? bus : hi_q;
    lo_d     = LOin     ? bus : lo_q;
    y_d      = Yin      ? bus : y_q;
    pc_d     = PCin     ? bus : pc_q;
    ir_d     = IRin     ? bus : ir_q;
    mar_d    = MARin    ? bus : mar_q;
    inport_d = Inportin ? bus : inport_q;
    mdr_d    = MDRin    ? (Read ? Mdatain : bus) : mdr_q;
    c_d      = Cin      ? {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]} : c_q;
    z_d      = Zin      ? alu_res : z_q;
  end

  // Register bank with asynchronous clear of all state.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      c_q      <= '0;
      z_q      <= '0;
    end else begin
      r_q      <= r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      y_q      <= y_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      inport_q <= inport_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed transfers into datapath; expected register values are
// queued by the stimulus and compared by a separate monitor.
module tb_datapath;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // register ids: 0-15 Rn, then the special registers
  localparam int ID_HI = 16, ID_LO = 17, ID_Y = 18, ID_ZH = 19, ID_ZL = 20, ID_PC = 21;
  localparam int ID_IR = 22, ID_MAR = 23, ID_MDR = 24, ID_INP = 25, ID_C = 26;

  logic        Clock = 1'b0;
  logic        clear;
  logic        Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] rin, rout;
  logic        HIin, LOin, Yin, PCin, IRin, MARin, MDRin, Inportin, Cin, Zin;
  logic        HIout, LOout, Yout, PCout, IRout, MARout, MDRout, Inportout, Cout;
  logic        Zhighout, Zlowout;
  logic [31:0] Mdatain;

  typedef struct {
    int          id;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  event chk_now;

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin), .Zin(Zin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .PCout(PCout), .IRout(IRout),
    .MARout(MARout), .MDRout(MDRout), .Inportout(Inportout), .Cout(Cout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Mdatain(Mdatain)
  );

  function automatic logic [31:0] rd(input int id);
    case (id)
      0:  return dut.R0;   1:  return dut.R1;   2:  return dut.R2;   3:  return dut.R3;
      4:  return dut.R4;   5:  return dut.R5;   6:  return dut.R6;   7:  return dut.R7;
      8:  return dut.R8;   9:  return dut.R9;   10: return dut.R10;  11: return dut.R11;
      12: return dut.R12;  13: return dut.R13;  14: return dut.R14;  15: return dut.R15;
      ID_HI:  return dut.HI;
      ID_LO:  return dut.LO;
      ID_Y:   return dut.Y;
      ID_ZH:  return dut.Z[63:32];
      ID_ZL:  return dut.Z[31:0];
      ID_PC:  return dut.PC;
      ID_IR:  return dut.IR;
      ID_MAR: return dut.MAR;
      ID_MDR: return dut.MDR;
      ID_INP: return dut.Inport;
      ID_C:   return dut.C;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drain the scoreboard on each falling edge or on an explicit request.
  initial begin
    exp_t it;
    logic [31:0] got;
    forever begin
      @(negedge Clock or chk_now);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        got = rd(it.id);
        n_checks++;
        if (got !== it.val) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", it.nm, got, it.val);
        end
      end
    end
  end

  task automatic idle();
    rin = '0; rout = '0;
    {HIin, LOin, Yin, PCin, IRin, MARin, MDRin, Inportin, Cin, Zin} = '0;
    {HIout, LOout, Yout, PCout, IRout, MARout, MDRout, Inportout, Cout} = '0;
    Zhighout = 1'b0; Zlowout = 1'b0;
    Read = 1'b0; IncPC = 1'b0; opcode = OP_NONE;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic exp_push(input int id, input logic [31:0] v, input string nm);
    sb.push_back('{id, v, nm});
  endtask

  task automatic exp_z(input logic [31:0] hi, input logic [31:0] lo, input string nm);
    exp_push(ID_ZH, hi, {nm, "_zh"});
    exp_push(ID_ZL, lo, {nm, "_zl"});
  endtask

  task automatic mem_load(input logic [31:0] v);
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    tick();
  endtask

  // MDR drives B while Y is A; result captured into Z.
  task automatic alu_mdr(input logic [4:0] op);
    MDRout = 1'b1; opcode = op; Zin = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    Mdatain = '0;
    clear   = 1'b0;
    #12 clear = 1'b1;
    tick();

    // Fill every register with nonzero data so clearing is observable.
    mem_load(32'h1234_5678);
    exp_push(ID_MDR, 32'h1234_5678, "pre_mdr");
    MDRout = 1; rin = '1; HIin = 1; LOin = 1; Yin = 1; PCin = 1; IRin = 1;
    MARin = 1; Inportin = 1; Zin = 1; opcode = OP_ADD;
    tick();
    exp_push(5, 32'h1234_5678, "pre_r5");
    exp_push(ID_PC, 32'h1234_5678, "pre_pc");
    exp_z(32'h0, 32'h1234_5678, "pre_add");
    Cin = 1;
    tick();
    exp_push(ID_C, 32'hFFFC_5678, "pre_c_sext");

    // Asynchronous clear in the middle of a cycle.
    @(posedge Clock);
    #2 clear = 1'b0;
    #1;
    for (int i = 0; i <= ID_C; i++) exp_push(i, 32'h0, $sformatf("reset_%0d", i));
    ->chk_now;
    #1 clear = 1'b1;

    // Load path.
    mem_load(32'hFFFF_FFFA);
    exp_push(ID_MDR, 32'hFFFF_FFFA, "ld_mdr");
    MDRout = 1; rin[2] = 1; tick();
    exp_push(2, 32'hFFFF_FFFA, "ld_r2");
    mem_load(32'hFFFF_FFFB);
    MDRout = 1; rin[3] = 1; tick();
    exp_push(3, 32'hFFFF_FFFB, "ld_r3");
    mem_load(32'h0000_0008);
    MDRout = 1; rin[1] = 1; tick();
    exp_push(1, 32'h0000_0008, "ld_r1");

    // Fetch.
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    exp_push(ID_MAR, 32'h0, "fetch_mar");
    exp_z(32'h0, 32'h1, "fetch_inc");
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h1891_8000; tick();
    exp_push(ID_PC, 32'h1, "fetch_pc");
    exp_push(ID_MDR, 32'h1891_8000, "fetch_mdr");
    MDRout = 1; IRin = 1; tick();
    exp_push(ID_IR, 32'h1891_8000, "fetch_ir");
    Cin = 1; tick();
    Cout = 1; rin[4] = 1; tick();
    exp_push(4, 32'h0001_8000, "c_pos_r4");

    // Add: -6 + -5.
    rout[2] = 1; Yin = 1; tick();
    exp_push(ID_Y, 32'hFFFF_FFFA, "add_y");
    rout[3] = 1; opcode = OP_ADD; Zin = 1; tick();
    exp_z(32'h0, 32'hFFFF_FFF5, "add");
    Zlowout = 1; rin[1] = 1; tick();
    exp_push(1, 32'hFFFF_FFF5, "add_r1");

    // Multiply: -6 * -5, then -6 * 0x18000.
    rout[3] = 1; opcode = OP_MUL; Zin = 1; tick();
    exp_z(32'h0, 32'h0000_001E, "mul_pos");
    rout[4] = 1; opcode = OP_MUL; Zin = 1; tick();
    exp_z(32'hFFFF_FFFF, 32'hFFF7_0000, "mul_neg");

    // Divide: 17/5, 17/0, -6/4.
    mem_load(32'd17);
    MDRout = 1; Yin = 1; tick();
    mem_load(32'd5);
    alu_mdr(OP_DIV);
    exp_z(32'd2, 32'd3, "div");
    Zhighout = 1; rin[6] = 1; tick();
    exp_push(6, 32'd2, "div_zhigh_r6");
    opcode = OP_DIV; Zin = 1; tick();
    exp_z(32'd17, 32'd0, "div_zero");
    rout[2] = 1; Yin = 1; tick();
    mem_load(32'd4);
    alu_mdr(OP_DIV);
    exp_z(32'hFFFF_FFFE, 32'hFFFF_FFFF, "div_neg");

    // Shifts and rotates of 0x80000001 by 1.
    mem_load(32'h8000_0001);
    MDRout = 1; Yin = 1; tick();
    mem_load(32'h1);
    alu_mdr(OP_SHR);  exp_z(32'h0, 32'h4000_0000, "shr");
    alu_mdr(OP_SHRA); exp_z(32'h0, 32'hC000_0000, "shra");
    alu_mdr(OP_SHL);  exp_z(32'h0, 32'h0000_0002, "shl");
    alu_mdr(OP_ROR);  exp_z(32'h0, 32'hC000_0000, "ror");
    alu_mdr(OP_ROL);  exp_z(32'h0, 32'h0000_0003, "rol");

    // Logic and arithmetic on 0xF0 / 0x3C.
    mem_load(32'h0000_00F0);
    MDRout = 1; Yin = 1; tick();
    mem_load(32'h0000_003C);
    alu_mdr(OP_AND);  exp_push(ID_ZL, 32'h0000_0030, "and");
    alu_mdr(OP_OR);   exp_push(ID_ZL, 32'h0000_00FC, "or");
    alu_mdr(OP_SUB);  exp_push(ID_ZL, 32'h0000_00B4, "sub");
    alu_mdr(OP_NEG);  exp_push(ID_ZL, 32'hFFFF_FFC4, "neg");
    alu_mdr(OP_NONE); exp_push(ID_ZL, 32'h0, "undef_op");
    opcode = OP_NOT; Zin = 1; tick();
    exp_z(32'h0, 32'hFFFF_FFFF, "not_zero_bus");

    // HI, LO, Inport round-trips.
    MDRout = 1; HIin = 1; LOin = 1; Inportin = 1; tick();
    exp_push(ID_INP, 32'h0000_003C, "inport");
    LOout = 1; rin[10] = 1; tick();
    exp_push(10, 32'h0000_003C, "lo_r10");

    // Overlapping drive strobes resolve by priority.
    rout[2] = 1; rout[3] = 1; HIout = 1; rin[8] = 1; tick();
    exp_push(8, 32'hFFFF_FFFA, "prio_r2");
    HIout = 1; MARout = 1; Yout = 1; rin[11] = 1; tick();
    exp_push(11, 32'h0000_003C, "prio_hi");

    // Same register driving and loading in one cycle.
    MDRout = 1; MDRin = 1; Read = 1; Mdatain = 32'hA5A5_A5A5; rin[7] = 1; tick();
    exp_push(7, 32'h0000_003C, "same_old");
    exp_push(ID_MDR, 32'hA5A5_A5A5, "same_new");

    // IncPC ignores the opcode.
    PCout = 1; IncPC = 1; opcode = OP_SUB; Zin = 1; tick();
    exp_z(32'h0, 32'h2, "incpc");
    Zlowout = 1; PCin = 1; tick();
    exp_push(ID_PC, 32'h2, "pc2");

    // Negative sign extension into C.
    mem_load(32'h0004_0005);
    MDRout = 1; IRin = 1; tick();
    Cin = 1; tick();
    exp_push(ID_C, 32'hFFFC_0005, "c_neg");

    tick();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
